// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter sharing one 8N1 UART TX line among requesters
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int ID_W         = 2,
   parameter int CLKS_PER_BIT = 10417
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     i_req_valid,
   input  logic [8*NUM_REQ-1:0]   i_req_data,
   output logic [NUM_REQ-1:0]     o_ack,
   output logic [ID_W-1:0]        o_active_id,
   output logic                   o_busy,
   output logic                   o_frame_done,
   output logic                   o_tx
);

   localparam int                c_cnt_w   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t               r_state,     w_state_nxt;
   logic [c_cnt_w-1:0]   r_cnt,       w_cnt_nxt;
   logic [2:0]           r_bit_idx,   w_bit_idx_nxt;
   logic [7:0]           r_shift,     w_shift_nxt;
   logic [ID_W-1:0]      r_last,      w_last_nxt;
   logic [ID_W-1:0]      r_active_id, w_active_id_nxt;
   logic [NUM_REQ-1:0]   r_ack,       w_ack_nxt;
   logic                 r_tx,        w_tx_nxt;

   logic                 w_bit_end;
   logic                 w_found;
   logic [ID_W-1:0]      w_grant_idx;
   logic [7:0]           w_grant_byte;

   function automatic logic [ID_W-1:0] f_rr_idx(input logic [ID_W-1:0] last_id, input int step);
      return ID_W'((int'(last_id) + step) % NUM_REQ);
   endfunction

   // Scan farthest-to-nearest so the candidate closest after r_last wins.
   always_comb begin
      w_found     = 1'b0;
      w_grant_idx = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (i_req_valid[f_rr_idx(r_last, k)]) begin
            w_found     = 1'b1;
            w_grant_idx = f_rr_idx(r_last, k);
         end
      end
   end

   always_comb begin
      w_grant_byte = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant_idx == ID_W'(i)) begin
            w_grant_byte = i_req_data[8*i +: 8];
         end
      end
   end

   assign w_bit_end = (r_cnt == c_cnt_max);

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = (w_bit_end) ? '0 : r_cnt + c_cnt_w'(1);
      w_bit_idx_nxt   = r_bit_idx;
      w_shift_nxt     = r_shift;
      w_last_nxt      = r_last;
      w_active_id_nxt = r_active_id;
      w_ack_nxt       = '0;
      w_tx_nxt        = 1'b1;

      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (w_found) begin
               w_ack_nxt[w_grant_idx] = 1'b1;
               w_shift_nxt            = w_grant_byte;
               w_active_id_nxt        = w_grant_idx;
               w_last_nxt             = w_grant_idx;
               w_bit_idx_nxt          = '0;
               w_state_nxt            = S_START;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_bit_idx_nxt = '0;
               w_state_nxt   = S_DATA;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_shift_nxt = {1'b0, r_shift[7:1]};
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = S_STOP;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Line level is registered from the next state so o_tx never glitches.
      case (w_state_nxt)
         S_START: w_tx_nxt = 1'b0;
         S_DATA:  w_tx_nxt = w_shift_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_last      <= ID_W'(NUM_REQ - 1);
         r_active_id <= '0;
         r_ack       <= '0;
         r_tx        <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_bit_idx   <= w_bit_idx_nxt;
         r_shift     <= w_shift_nxt;
         r_last      <= w_last_nxt;
         r_active_id <= w_active_id_nxt;
         r_ack       <= w_ack_nxt;
         r_tx        <= w_tx_nxt;
      end
   end

   assign o_ack        = r_ack;
   assign o_active_id  = r_active_id;
   assign o_busy       = (r_state != S_IDLE);
   assign o_frame_done = (r_state == S_STOP) && w_bit_end;
   assign o_tx         = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// Testbench for uart_tx_arbiter: frame-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_arbiter;

   localparam int NR  = 4;
   localparam int IW  = 2;
   localparam int CPB = 4;
   localparam int FR  = 10 * CPB;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [8*NR-1:0]   req_data = '0;
   logic [NR-1:0]     ack;
   logic [IW-1:0]     active_id;
   logic              busy;
   logic              frame_done;
   logic              tx;

   int errors = 0;
   int checks = 0;

   uart_tx_arbiter #(
      .NUM_REQ      (NR),
      .ID_W         (IW),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_req_valid  (req_valid),
      .i_req_data   (req_data),
      .o_ack        (ack),
      .o_active_id  (active_id),
      .o_busy       (busy),
      .o_frame_done (frame_done),
      .o_tx         (tx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: frame position counter ----------------
   int            m_t = -1;          // cycle offset inside current frame, -1 = idle
   logic [7:0]    m_byte = '0;
   int            m_last = NR - 1;
   int            m_id = 0;
   logic [NR-1:0] m_ack = '0;
   int            mc;

   function automatic logic exp_tx(input int t, input logic [7:0] b);
      int bi;
      if (t < 0) return 1'b1;
      bi = t / CPB;
      if (bi == 0) return 1'b0;
      if (bi <= 8) return b[bi-1];
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         m_t = -1; m_last = NR - 1; m_id = 0; m_ack = '0;
      end
      chk("ack",        32'(ack),        32'(m_ack));
      chk("active_id",  32'(active_id),  32'(m_id));
      chk("busy",       32'(busy),       32'(m_t >= 0));
      chk("frame_done", 32'(frame_done), 32'(m_t == FR - 1));
      chk("tx",         32'(tx),         32'(exp_tx(m_t, m_byte)));
      if (rst_n) begin
         m_ack = '0;
         if (m_t >= 0) begin
            m_t++;
            if (m_t == FR) m_t = -1;
         end else begin
            for (int k = 1; k <= NR; k++) begin
               mc = (m_last + k) % NR;
               if (req_valid[mc]) begin
                  m_ack[mc] = 1'b1;
                  m_byte    = req_data[8*mc +: 8];
                  m_id      = mc;
                  m_last    = mc;
                  m_t       = 0;
                  break;
               end
            end
         end
      end
   end

   // ---------------- stimulus and directed literal checks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      chk(name, 32'(busy), 32'd0);
   endtask

   function automatic int onehot_idx(input logic [NR-1:0] v);
      int r = -1;
      for (int i = 0; i < NR; i++) if (v[i]) r = i;
      return r;
   endfunction

   initial begin
      logic [9:0] sf_bits;
      int         rr_id  [5];
      int         rr_cyc [5];
      int         n;
      int         cyc;
      logic       seen3;
      logic       fd_seen;

      // Reset held with requests pending
      req_valid = '1;
      req_data  = 32'hDEAD_BEEF;
      repeat (5) begin
         tick();
         chk("rst_tx",   32'(tx),   32'd1);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_ack",  32'(ack),  32'd0);
      end
      req_valid = '0;
      rst_n     = 1'b1;
      repeat (8) tick();
      chk("idle_busy", 32'(busy), 32'd0);

      // Single frame: requester 2 sends A5, data changed right after ack
      sf_bits = 10'b1101001010;
      req_valid = 4'b0100;
      req_data[23:16] = 8'hA5;
      tick();
      chk("sf_ack", 32'(ack), 32'h4);
      chk("sf_id",  32'(active_id), 32'd2);
      req_valid = '0;
      req_data[23:16] = 8'h00;
      for (int c = 1; c <= 41; c++) begin
         if (c <= 40 && ((c - 1) % CPB) == 1)
            chk("sf_tx", 32'(tx), 32'(sf_bits[(c-1)/CPB]));
         if (c == 39 || c == 40) chk("sf_fd",   32'(frame_done), 32'(c == 40));
         if (c == 40 || c == 41) chk("sf_busy", 32'(busy),       32'(c == 40));
         if (c < 41) tick();
      end

      // Round-robin with every requester continuously valid
      do_reset();
      req_valid = '1;
      req_data  = 32'h4433_2211;
      n = 0; cyc = 0;
      while (n < 5 && cyc < 400) begin
         tick();
         cyc++;
         if (ack != '0) begin
            rr_id[n]  = onehot_idx(ack);
            rr_cyc[n] = cyc;
            n++;
         end
      end
      chk("rr_count", 32'(n), 32'd5);
      for (int k = 0; k < n; k++) begin
         chk("rr_order", 32'(rr_id[k]), 32'(k % NR));
         if (k > 0) chk("rr_gap", 32'(rr_cyc[k] - rr_cyc[k-1]), 32'(FR + 1));
      end
      req_valid = '0;
      wait_idle("rr_idle");

      // Mid-frame request (1) and withdrawal (3)
      do_reset();
      req_valid = 4'b0001;
      req_data  = 32'h0000_003C;
      tick();
      chk("mf_ack0", 32'(ack), 32'h1);
      req_valid = '0;
      seen3 = 1'b0;
      repeat (5) tick();
      req_valid[1] = 1'b1; req_data[15:8] = 8'h96;
      req_valid[3] = 1'b1; req_data[31:24] = 8'h55;
      repeat (10) tick();
      req_valid[3] = 1'b0;
      n = 0;
      while (!frame_done && n < 60) begin
         tick();
         n++;
         if (ack[3]) seen3 = 1'b1;
      end
      chk("mf_fd_seen", 32'(frame_done), 32'd1);
      tick();
      chk("mf_gap_ack",  32'(ack),  32'h0);
      chk("mf_gap_busy", 32'(busy), 32'h0);
      tick();
      chk("mf_ack1", 32'(ack), 32'h2);
      req_valid[1] = 1'b0;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (ack[3]) seen3 = 1'b1;
      end
      chk("mf_no_ack3", 32'(seen3), 32'd0);

      // Reset during data bit 4, then re-arbitration from requester 0
      do_reset();
      req_valid = 4'b0001;
      req_data  = 32'h0000_00FF;
      tick();
      chk("mr_ack0", 32'(ack), 32'h1);
      req_valid = 4'b1001;
      repeat (21) tick();
      chk("mr_in_frame", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mr_tx_async",   32'(tx),   32'd1);
      chk("mr_busy_async", 32'(busy), 32'd0);
      fd_seen = 1'b0;
      repeat (3) begin
         tick();
         if (frame_done) fd_seen = 1'b1;
      end
      chk("mr_no_fd", 32'(fd_seen), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("mr_rearb", 32'(ack), 32'h1);
      req_valid = '0;
      wait_idle("mr_idle");

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         tick();
         for (int i = 0; i < NR; i++) begin
            if (ack[i]) begin
               req_valid[i] = 1'b0;
               req_data[8*i +: 8] = 8'($urandom);
            end else if (req_valid[i]) begin
               if ($urandom_range(0, 299) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 40) == 0) begin
               req_valid[i] = 1'b1;
               req_data[8*i +: 8] = 8'($urandom);
            end
         end
         if ($urandom_range(0, 1499) == 0) begin
            rst_n = 1'b0;
            tick();
            tick();
            rst_n = 1'b1;
         end
      end
      req_valid = '0;
      tick();
      wait_idle("rand_idle");
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one serial UART transmit line between NUM_REQ requesters using round-robin arbitration.
- Contains its own baud-period counter. It generates the same per-bit timing as the team's 9600-baud clock divider, but as an enable count rather than a divided clock.
- Serializes each granted byte as 8N1: 1 start bit, 8 data bits, 1 stop bit.
- Sits between the console/debug message sources and the board TX pin.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of the granted-requester index; must equal ceil(log2(NUM_REQ)).
- CLKS_PER_BIT, 10417, clk cycles per serial bit (100 MHz / 9600 baud); minimum 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request; hold high, with data stable, until its ack.
- req_data  in  8*NUM_REQ  byte per requester; requester i uses bits [8i+7:8i].
- ack  out  NUM_REQ  one-cycle pulse to the granted requester; its byte is captured on this edge.
- active_id  out  ID_W  index of the requester currently being transmitted.
- busy  out  1  high from grant until the end of the stop bit.
- frame_done  out  1  one-cycle pulse on the last cycle of the stop bit.
- tx  out  1  serial output; idles high.

Behaviour:
- Reset (async on rst_n low, released synchronously to clk):
  - outputs: tx=1, busy=0, ack=0, frame_done=0, active_id=0.
  - internal: state=IDLE, baud counter=0, bit index=0, round-robin pointer last=NUM_REQ-1 (so requester 0 has top priority first).
  - Reset mid-frame aborts immediately: tx returns high, the partial byte is dropped, and no ack or frame_done is produced.
- Arbitration, in IDLE only:
  - Each cycle, search for the first i with req_valid[i]=1, in the order last+1, last+2, ..., wrapping modulo NUM_REQ.
  - On the next edge: ack[i]=1 for exactly one cycle; shift register <= req_data[i]; active_id <= i; last <= i; busy <= 1; tx <= 0; state -> START; baud counter <= 0.
  - Requests arriving during a frame wait; they are not queued beyond req_valid.
  - A requester that drops req_valid before its ack is simply not served.
- Bit timing:
  - The baud counter runs 0..CLKS_PER_BIT-1. Each bit lasts exactly CLKS_PER_BIT cycles.
  - Bit boundary = cycle with counter == CLKS_PER_BIT-1; the counter wraps to 0 on that edge.
- State machine:
  - IDLE -> START on grant.
  - START (tx=0, 1 bit) -> DATA.
  - DATA: 8 bits, LSB first; tx = shift[0]; shift right at each bit boundary; bit index counts 0..7 and leaves at 7 -> STOP.
  - STOP (tx=1, 1 bit): frame_done=1 on its final cycle; on that edge busy <= 0 and state -> IDLE.
- Frame length: 10*CLKS_PER_BIT cycles from the tx falling edge to the start of IDLE.
- Back-to-back frames:
  - Minimum gap is 1 IDLE cycle (arbitration cycle) between frames.
  - The next start bit begins 10*CLKS_PER_BIT+1 cycles after the previous start bit.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0,...
- Simultaneous events:
  - ack is never asserted while busy was already 1 before that edge.
  - req_data changes after ack do not affect the frame in flight.
  - active_id holds its value after the frame until the next grant.

Test Plan (CLKS_PER_BIT=4, NUM_REQ=4):
- Reset check: hold rst_n=0, drive requests -> tx=1, busy=0, ack=0 throughout. Release rst_n -> no spurious activity without req_valid.
- Single frame:
  - Stimulus: req_valid=4'b0100, req_data[23:16]=8'hA5 at cycle 0.
  - Required: ack=4'b0100 at cycle 1; active_id=2.
  - Required tx per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 1.
  - Required: frame_done on cycle 40; busy low from cycle 41.
- Round-robin:
  - Stimulus: all req_valid=1, held continuously.
  - Required: ack order 0,1,2,3,0, with start bits spaced exactly 41 cycles apart.
- Mid-frame request and withdrawal:
  - Stimulus: requester 1 raises req_valid during requester 0's frame; requester 3 raises then drops it before the frame ends.
  - Required: requester 1 is granted the cycle after frame_done; requester 3 is never acked.
- Reset mid-frame: assert rst_n=0 during DATA bit 4 -> tx=1 immediately (asynchronous); no frame_done. After release, pending requests are re-arbitrated starting from requester 0.
- Data stability: change req_data[i] the cycle after ack -> the transmitted bits match the value captured at ack.
